key_debounce_lp: RTL

//  Per-key front end between raw push-button pins and the control FSM / alarm-set logic.
//  - Synchronises the raw key and debounces it.
//  - Emits one-cycle press/release pulses and a debounced level.
//  - Adds long-press detection and auto-repeat (fast increment while "plus" is held).
//  - One instance per key; all outputs are in the clk domain.

---
 rtl/key_debounce_lp.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/key_debounce_lp.sv
// Per-key push-button front end: 2-FF synchroniser, debouncer, press/release
// pulses, debounced level, long-press detection and auto-repeat.
// DEBOUNCE_CYC, LONG_CYC and REPEAT_CYC must each be >= 2.

module key_debounce_lp #(
   parameter int unsigned DEBOUNCE_CYC = 1_000_000,
   parameter int unsigned LONG_CYC     = 50_000_000,
   parameter int unsigned REPEAT_CYC   = 10_000_000,
   parameter bit          ACTIVE_LOW   = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic key_in,
   output logic key_flag,
   output logic key_state,
   output logic release_flag,
   output logic long_flag,
   output logic repeat_flag
);

   localparam int unsigned MAX_DL  = (DEBOUNCE_CYC > LONG_CYC) ? DEBOUNCE_CYC : LONG_CYC;
   localparam int unsigned MAX_CYC = (MAX_DL > REPEAT_CYC) ? MAX_DL : REPEAT_CYC;
   localparam int          CNT_W   = $clog2(MAX_CYC + 1);

   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   // Pin level that means "not pressed"; the synchroniser resets to it so no
   // phantom press is seen after reset.
   localparam logic RELEASED = ACTIVE_LOW ? 1'b1 : 1'b0;

   typedef enum logic [2:0] {
      IDLE,
      DB_PRESS,
      HELD,
      LONG,
      DB_REL
   } state_t;

   logic [1:0]       sync;
   logic             p;
   state_t           state, state_nxt;
   state_t           origin, origin_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             key_nxt, rel_nxt, long_nxt, rep_nxt;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge value of its neighbours; blocking here would collapse the
   // two synchroniser stages into one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync <= {2{RELEASED}};
      end else begin
         sync <= {sync[0], key_in};
      end
   end

   assign p = ACTIVE_LOW ? ~sync[1] : sync[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         origin       <= HELD;
         cnt          <= '0;
         key_flag     <= 1'b0;
         release_flag <= 1'b0;
         long_flag    <= 1'b0;
         repeat_flag  <= 1'b0;
      end else begin
         state        <= state_nxt;
         origin       <= origin_nxt;
         cnt          <= cnt_nxt;
         key_flag     <= key_nxt;
         release_flag <= rel_nxt;
         long_flag    <= long_nxt;
         repeat_flag  <= rep_nxt;
      end
   end

   // The counter clears on every state change and on each repeat match, so
   // equality compares are sufficient and it can never wrap.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      state_nxt  = state;
      origin_nxt = origin;
      cnt_nxt    = cnt;
      key_nxt    = 1'b0;
      rel_nxt    = 1'b0;
      long_nxt   = 1'b0;
      rep_nxt    = 1'b0;

      unique case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (p) state_nxt = DB_PRESS;
         end
         DB_PRESS: begin
            if (!p) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (cnt == DB_LAST) begin
               key_nxt   = 1'b1;
               state_nxt = HELD;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         HELD: begin
            if (!p) begin
               state_nxt  = DB_REL;
               origin_nxt = HELD;
               cnt_nxt    = '0;
            end else if (cnt == LONG_LAST) begin
               long_nxt  = 1'b1;
               state_nxt = LONG;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         LONG: begin
            if (!p) begin
               state_nxt  = DB_REL;
               origin_nxt = LONG;
               cnt_nxt    = '0;
            end else if (cnt == REP_LAST) begin
               rep_nxt = 1'b1;
               cnt_nxt = '0;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         DB_REL: begin
            // A bounce back to pressed resumes the hold phase with a fresh count.
            if (p) begin
               state_nxt = origin;
               cnt_nxt   = '0;
            end else if (cnt == DB_LAST) begin
               rel_nxt   = 1'b1;
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // The level follows the pulses, so it changes one cycle after each of them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_state <= 1'b0;
      end else if (key_flag) begin
         key_state <= 1'b1;
      end else if (release_flag) begin
         key_state <= 1'b0;
      end
   end

endmodule
